pipe_reg: RTL and testbench

Parametrised elastic pipeline register. It extends the plain enabled D flip-flop to a chain of `depth` stages, each `n` bits wide, with a per-stage valid bit, a valid/ready handshake on both sides, bubble collapsing, a global stall (`enable`) and a synchronous `flush`. It sits between datapath stages, for example IF/ID or ID/EX, where stalls and branch flushes must be absorbed without losing or duplicating words.

---
 rtl/pipe_reg_if.sv | 13 +
 rtl/pipe_reg.sv | 68 ++++++
 tb/tb_pipe_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_reg_if.sv
// Handshake bundle for pipe_reg: upstream valid/ready/data in, downstream valid/ready/data out.
interface pipe_reg_if #(parameter int n = 32);
  logic         in_valid;
  logic         in_ready;
  logic [n-1:0] d;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] q;

  // master: the surrounding datapath; slave: the pipeline register itself
  modport master (output in_valid, d, out_ready, input in_ready, out_valid, q);
  modport slave  (input in_valid, d, out_ready, output in_ready, out_valid, q);
endinterface

// File: rtl/pipe_reg.sv
// Elastic pipeline register: depth stages of n bits with per-stage valid,
// valid/ready on both ends, bubble collapsing, global stall and flush.
module pipe_reg #(
  parameter int n     = 32,
  parameter int depth = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       flush,
  pipe_reg_if.slave                  bus,
  output logic [$clog2(depth+1)-1:0] count
);

  localparam int cw = $clog2(depth + 1);

  logic [n-1:0]     data     [depth];
  logic [n-1:0]     src_data [depth];
  logic [depth-1:0] valid;
  logic [depth-1:0] acc;
  logic [depth-1:0] src_valid;
  logic             run;

  // Accept chain scanned from the output end through a running term,
  // so acc is never read back inside its own process.
  always_comb begin
    logic a;
    a   = ~valid[depth-1] | bus.out_ready;
    acc = '0;
    acc[depth-1] = a;
    for (int unsigned k = 1; k < depth; k++) begin
      a = ~valid[depth-1-k] | a;
      acc[depth-1-k] = a;
    end
  end

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.d;
    for (int unsigned k = 1; k < depth; k++) begin
      src_valid[k] = valid[k-1];
      src_data[k]  = data[k-1];
    end
  end

  assign run           = enable & ~flush & ~reset;
  assign bus.in_ready  = acc[0] & run;
  assign bus.out_valid = valid[depth-1] & run;
  assign bus.q         = data[depth-1];
  assign count         = cw'($countones(valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      for (int unsigned k = 0; k < depth; k++) data[k] <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (enable) begin
      for (int unsigned k = 0; k < depth; k++) begin
        if (acc[k]) begin
          valid[k] <= src_valid[k];
          if (src_valid[k]) data[k] <= src_data[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg.sv
// Scoreboard bench for pipe_reg: depth-2 instance for stream/backpressure/stall/flush,
// depth-3 instance for bubble collapse.
module tb_pipe_reg;
  logic       clk = 1'b0;
  logic       reset, enable, flush;
  logic [1:0] count2, count3;

  pipe_reg_if #(.n(32)) b2 ();
  pipe_reg_if #(.n(32)) b3 ();

  pipe_reg #(.n(32), .depth(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(b2), .count(count2)
  );
  pipe_reg #(.n(32), .depth(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .bus(b3), .count(count3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard on the depth-2 instance: transfers resolved mid-cycle
  always @(negedge clk) begin
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (b2.out_valid && b2.out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_out", 32'(exp_q.size()), 32'd1);
        else check("sb_data", b2.q, exp_q.pop_front());
      end
      if (b2.in_valid && b2.in_ready) exp_q.push_back(b2.d);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] sv [3];
    logic [31:0] w  [5];
    sv = '{32'h11, 32'h22, 32'h33};
    w  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104};

    reset = 1'b1; enable = 1'b1; flush = 1'b0;
    b2.in_valid = 1'b0; b2.d = '0; b2.out_ready = 1'b0;
    b3.in_valid = 1'b0; b3.d = '0; b3.out_ready = 1'b0;

    // Reset held for two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      cyc();
      b2.in_valid = 1'($urandom_range(0, 1));
      b2.d = $urandom;
      b2.out_ready = 1'($urandom_range(0, 1));
      mid();
      check("rst_q", b2.q, 32'd0);
      check("rst_ov", b2.out_valid, 32'd0);
      check("rst_cnt", count2, 32'd0);
      check("rst_ir", b2.in_ready, 32'd0);
    end

    cyc();
    reset = 1'b0; b2.in_valid = 1'b0; b2.out_ready = 1'b1;
    mid();
    check("empty_ir", b2.in_ready, 32'd1);
    check("empty_ov", b2.out_valid, 32'd0);

    // Streaming: out_valid two cycles after first accept, one word per cycle
    for (int i = 0; i < 6; i++) begin
      cyc();
      b2.in_valid = (i < 3);
      b2.d = (i < 3) ? sv[i] : 32'd0;
      mid();
      if (i == 0) check("str_ir", b2.in_ready, 32'd1);
      check("str_ov", b2.out_valid, (i >= 2 && i <= 4) ? 32'd1 : 32'd0);
      if (i >= 2 && i <= 4) check("str_q", b2.q, sv[i-2]);
      check("str_cnt_le2", 32'(count2 <= 2'd2), 32'd1);
    end

    // Backpressure until full, then release
    cyc(); b2.out_ready = 1'b0; b2.in_valid = 1'b1; b2.d = 32'hA;
    mid(); check("bp_ir_a", b2.in_ready, 32'd1);
    cyc(); b2.d = 32'hB;
    mid(); check("bp_ir_b", b2.in_ready, 32'd1);
    cyc(); b2.d = 32'hC;
    mid();
    check("bp_full_ir", b2.in_ready, 32'd0);
    check("bp_full_cnt", count2, 32'd2);
    check("bp_full_q", b2.q, 32'hA);
    cyc();
    mid(); check("bp_full_ir2", b2.in_ready, 32'd0);
    cyc(); b2.out_ready = 1'b1;
    mid(); check("bp_pushpop_ir", b2.in_ready, 32'd1);
    cyc(); b2.in_valid = 1'b0;
    mid(); check("bp_pushpop_cnt", count2, 32'd2);
    drain("bp_drain");

    // Stall for three cycles mid-stream
    for (int i = 0; i < 3; i++) begin
      cyc(); b2.in_valid = 1'b1; b2.d = w[i];
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); enable = 1'b0; b2.d = w[3];
      mid();
      check("st_ir", b2.in_ready, 32'd0);
      check("st_ov", b2.out_valid, 32'd0);
      check("st_cnt", count2, 32'd2);
      check("st_q", b2.q, w[1]);
    end
    cyc(); enable = 1'b1; b2.d = w[3];
    cyc(); b2.d = w[4];
    cyc(); b2.in_valid = 1'b0;
    drain("st_drain");

    // Flush with a word offered
    cyc(); b2.out_ready = 1'b0; b2.in_valid = 1'b1; b2.d = 32'h55;
    cyc(); b2.d = 32'h66;
    cyc(); flush = 1'b1; b2.d = 32'hFF;
    mid();
    check("fl_ir", b2.in_ready, 32'd0);
    check("fl_ov", b2.out_valid, 32'd0);
    check("fl_cnt_before", count2, 32'd2);
    cyc(); flush = 1'b0; b2.in_valid = 1'b0;
    mid();
    check("fl_cnt", count2, 32'd0);
    check("fl_ov_next", b2.out_valid, 32'd0);
    b2.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); mid();
      check("fl_ov_after", b2.out_valid, 32'd0);
      check("fl_no_ff", 32'(b2.q == 32'hFF), 32'd0);
    end

    // Flush while stalled
    cyc(); b2.out_ready = 1'b0; b2.in_valid = 1'b1; b2.d = 32'h77;
    cyc(); b2.in_valid = 1'b0; enable = 1'b0; flush = 1'b1;
    mid(); check("fe_cnt_before", count2, 32'd1);
    cyc(); enable = 1'b1; flush = 1'b0;
    mid(); check("fe_cnt", count2, 32'd0);

    // Reset mid-stream, pipe usable immediately afterwards
    cyc(); b2.in_valid = 1'b1; b2.d = 32'h88;
    cyc(); b2.in_valid = 1'b0; reset = 1'b1;
    cyc(); reset = 1'b0; b2.out_ready = 1'b1; b2.in_valid = 1'b1; b2.d = 32'h99;
    mid();
    check("rm_cnt", count2, 32'd0);
    check("rm_q", b2.q, 32'd0);
    check("rm_ir", b2.in_ready, 32'd1);
    cyc(); b2.in_valid = 1'b0;
    drain("rm_drain");

    // Bubble collapse on depth 3
    cyc(); b3.in_valid = 1'b1; b3.d = 32'h1;
    mid(); check("bc_ir", b3.in_ready, 32'd1);
    cyc(); b3.in_valid = 1'b0;
    cyc(); b3.in_valid = 1'b1; b3.d = 32'h2;
    cyc(); b3.in_valid = 1'b0;
    mid(); check("bc_cnt", count3, 32'd2);
    cyc(); mid();
    check("bc_cnt_hold", count3, 32'd2);
    check("bc_ov", b3.out_valid, 32'd1);
    check("bc_q_s2", b3.q, 32'h1);
    cyc(); b3.out_ready = 1'b1;
    mid(); check("bc_q_pop1", b3.q, 32'h1);
    cyc(); mid();
    check("bc_ov_s1", b3.out_valid, 32'd1);
    check("bc_q_s1", b3.q, 32'h2);
    cyc(); mid();
    check("bc_ov_empty", b3.out_valid, 32'd0);
    check("bc_cnt_empty", count3, 32'd0);

    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
